store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 155 +++++++++++++++
 tb/tb_store_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit: formats SB/SH/SW store requests, buffers them in a 2-entry
// FIFO and drains them to data memory through a simple req/ack handshake.
// Optional build macro: STORE_MISALIGN_TRAP_EN
//   defined   -> misaligned SH/SW and illegal funct3 are rejected and pulse
//                misaligned_out for one cycle
//   undefined -> misaligned SH/SW are forced to alignment and enqueued,
//                illegal funct3 is dropped silently, misaligned_out is tied 0
//
// Drain FSM
//   state | meaning
//   IDLE  | nothing in flight, memory interface quiet
//   REQ   | head entry presented to memory, waiting for dmem_ack_in
module store_unit (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        store_in,
  input  logic [2:0]  store_funct3_in,
  input  logic [31:0] iaddr_in,
  input  logic [31:0] rs2_in,
  output logic        store_ready_out,
  output logic        dmem_wr_req_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_ack_in,
  output logic        misaligned_out,
  output logic        buf_empty_out
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] addr_mem  [2];
  logic [31:0] wdata_mem [2];
  logic [3:0]  mask_mem  [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_nxt;
  logic        ready_q;

  logic        legal;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_mask;
  logic        reject;
  logic        accept, push, pop;

  // Lane replication and byte enables for the incoming request
  always_comb begin
    legal     = 1'b0;
    fmt_wdata = '0;
    fmt_mask  = '0;
    case (store_funct3_in)
      3'b000: begin
        legal     = 1'b1;
        fmt_wdata = {4{rs2_in[7:0]}};
        fmt_mask  = 4'b0001 << iaddr_in[1:0];
      end
      3'b001: begin
        legal     = 1'b1;
        fmt_wdata = {2{rs2_in[15:0]}};
        fmt_mask  = iaddr_in[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        legal     = 1'b1;
        fmt_wdata = rs2_in;
        fmt_mask  = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign;
  logic mis_q;

  assign misalign = ((store_funct3_in == 3'b001) && iaddr_in[0]) ||
                    ((store_funct3_in == 3'b010) && (iaddr_in[1:0] != 2'b00));
  assign reject   = !legal || misalign;

  // One-cycle pulse for every accepted-but-rejected request
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) mis_q <= 1'b0;
    else           mis_q <= accept && reject;
  end

  assign misaligned_out = mis_q;
`else
  // Misaligned SH/SW are already aligned by the mask/address formatting
  assign reject         = !legal;
  assign misaligned_out = 1'b0;
`endif

  assign accept    = store_in && ready_q;
  assign push      = accept && !reject;
  assign pop       = (state_q == REQ) && dmem_ack_in;
  assign count_nxt = count_q + {1'b0, push} - {1'b0, pop};

  // FIFO storage and pointers; push and pop may share an edge
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 2; i++) begin
        addr_mem[i]  <= '0;
        wdata_mem[i] <= '0;
        mask_mem[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        addr_mem[wr_ptr_q]  <= {iaddr_in[31:2], 2'b00};
        wdata_mem[wr_ptr_q] <= fmt_wdata;
        mask_mem[wr_ptr_q]  <= fmt_mask;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_nxt;
  end

  // Next state looks at the post-edge occupancy so a store accepted into an
  // idle unit is requested in the very next cycle
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (count_nxt != 2'd0) state_nxt = REQ;
      REQ:     if (dmem_ack_in && (count_nxt == 2'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory interface outputs are zeroed whenever no request is active
  always_comb begin
    dmem_wr_req_out = (state_q == REQ);
    dmem_addr_out   = '0;
    dmem_wdata_out  = '0;
    dmem_wmask_out  = '0;
    if (dmem_wr_req_out) begin
      dmem_addr_out  = addr_mem[rd_ptr_q];
      dmem_wdata_out = wdata_mem[rd_ptr_q];
      dmem_wmask_out = mask_mem[rd_ptr_q];
    end
  end

  assign store_ready_out = ready_q;
  assign buf_empty_out   = (count_q == 2'd0) && (state_q == IDLE);

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed scenarios followed by random traffic, every cycle
// compared with a queue-based model of the store buffer.
module tb_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        store_in;
  logic [2:0]  store_funct3_in;
  logic [31:0] iaddr_in;
  logic [31:0] rs2_in;
  logic        store_ready_out;
  logic        dmem_wr_req_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        dmem_ack_in;
  logic        misaligned_out;
  logic        buf_empty_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } entry_t;

  entry_t q[$];
  logic   mis_exp = 1'b0;

  store_unit dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .store_in        (store_in),
    .store_funct3_in (store_funct3_in),
    .iaddr_in        (iaddr_in),
    .rs2_in          (rs2_in),
    .store_ready_out (store_ready_out),
    .dmem_wr_req_out (dmem_wr_req_out),
    .dmem_addr_out   (dmem_addr_out),
    .dmem_wdata_out  (dmem_wdata_out),
    .dmem_wmask_out  (dmem_wmask_out),
    .dmem_ack_in     (dmem_ack_in),
    .misaligned_out  (misaligned_out),
    .buf_empty_out   (buf_empty_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer
  task automatic check_all(input string tag);
    entry_t h;
    bit     busy;
    busy = (q.size() > 0);
    if (busy) h = q[0];
    else begin
      h.addr = 0; h.wdata = 0; h.mask = 0;
    end
    chk({tag, ".ready"}, {31'b0, store_ready_out}, {31'b0, q.size() < 2});
    chk({tag, ".req"},   {31'b0, dmem_wr_req_out}, {31'b0, busy});
    chk({tag, ".addr"},  dmem_addr_out, h.addr);
    chk({tag, ".wdata"}, dmem_wdata_out, h.wdata);
    chk({tag, ".mask"},  {28'b0, dmem_wmask_out}, {28'b0, h.mask});
    chk({tag, ".empty"}, {31'b0, buf_empty_out}, {31'b0, !busy});
    chk({tag, ".mis"},   {31'b0, misaligned_out}, {31'b0, mis_exp});
  endtask

  // Model edge: pop the head on ack, then append the formatted store
  task automatic model_edge();
    bit          accept, pop, legal, bad;
    int unsigned a;
    entry_t      e;
    accept = store_in && (q.size() < 2);
    pop    = (q.size() > 0) && dmem_ack_in;
    a      = iaddr_in;
    legal  = 1'b1;
    bad    = 1'b0;
    e.addr = (a / 4) * 4;
    case (store_funct3_in)
      3'd0: begin
        e.wdata = rs2_in[7:0] * 32'h01010101;
        e.mask  = 4'(1 << (a % 4));
      end
      3'd1: begin
        e.wdata = rs2_in[15:0] * 32'h00010001;
        e.mask  = 4'(3 << (a % 4 - a % 2));
        bad     = (a % 2) != 0;
      end
      3'd2: begin
        e.wdata = rs2_in;
        e.mask  = 4'hF;
        bad     = (a % 4) != 0;
      end
      default: begin
        legal   = 1'b0;
        e.wdata = 0;
        e.mask  = 0;
      end
    endcase
`ifdef STORE_MISALIGN_TRAP_EN
    mis_exp = accept && (!legal || bad);
    if (bad) legal = 1'b0;
`else
    mis_exp = 1'b0;
`endif
    if (pop) void'(q.pop_front());
    if (accept && legal) q.push_back(e);
  endtask

  task automatic step(input string tag, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input bit ack);
    store_in        = st;
    store_funct3_in = f3;
    iaddr_in        = a;
    rs2_in          = d;
    dmem_ack_in     = ack;
    @(posedge clk_in);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n_in = 1'b0;
    store_in = 1'b0;
    store_funct3_in = 3'd0;
    iaddr_in = '0;
    rs2_in = '0;
    dmem_ack_in = 1'b0;
    #12;
    check_all("reset");
    #10 rst_n_in = 1'b1;

    // SB at a byte-3 address
    step("sb", 1, 3'd0, 32'h1003, 32'hAABBCC5A, 0);
    chk("sb_wdata", dmem_wdata_out, 32'h5A5A5A5A);
    chk("sb_mask", {28'b0, dmem_wmask_out}, 32'h8);
    step("sb_hold", 0, 3'd0, 0, 0, 0);
    step("sb_ack", 0, 3'd0, 0, 0, 1);
    step("idle", 0, 3'd0, 0, 0, 1);

    // SH then SW back-to-back with ack held high
    step("sh", 1, 3'd1, 32'h22, 32'h1234, 1);
    chk("sh_mask", {28'b0, dmem_wmask_out}, 32'hC);
    chk("sh_wdata", dmem_wdata_out, 32'h12341234);
    step("sw", 1, 3'd2, 32'h40, 32'hDEADBEEF, 1);
    chk("sw_mask", {28'b0, dmem_wmask_out}, 32'hF);
    chk("sw_wdata", dmem_wdata_out, 32'hDEADBEEF);
    step("sw_done", 0, 3'd0, 0, 0, 1);

    // Full buffer: third store must be ignored
    step("full1", 1, 3'd2, 32'h100, 32'h11111111, 0);
    step("full2", 1, 3'd2, 32'h104, 32'h22222222, 0);
    chk("full_ready0", {31'b0, store_ready_out}, 0);
    step("full3", 1, 3'd2, 32'h108, 32'h33333333, 0);
    step("full_pop", 0, 3'd0, 0, 0, 1);
    chk("full_ready1", {31'b0, store_ready_out}, 1);
    chk("full_head", dmem_wdata_out, 32'h22222222);
    step("full_drain", 0, 3'd0, 0, 0, 1);
    step("full_idle", 0, 3'd0, 0, 0, 0);

    // Misaligned SW
    step("mis_sw", 1, 3'd2, 32'h102, 32'hCAFEF00D, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, misaligned_out}, 1);
    chk("mis_noreq", {31'b0, dmem_wr_req_out}, 0);
`else
    chk("mis_aligned_addr", dmem_addr_out, 32'h100);
`endif
    step("mis_after", 0, 3'd0, 0, 0, 1);
    step("mis_idle", 0, 3'd0, 0, 0, 1);

    // Illegal funct3
    step("illegal", 1, 3'd5, 32'h200, 32'h12345678, 0);
    step("illegal_after", 0, 3'd0, 0, 0, 0);

    // Reset during REQ with two pending entries
    step("rst_fill1", 1, 3'd2, 32'h300, 32'hA5A5A5A5, 0);
    step("rst_fill2", 1, 3'd0, 32'h305, 32'h000000EE, 0);
    #2 rst_n_in = 1'b0;
    #1;
    q.delete();
    mis_exp = 1'b0;
    check_all("rst_async");
    #2 rst_n_in = 1'b1;
    step("rst_post1", 0, 3'd0, 0, 0, 1);
    step("rst_post2", 0, 3'd0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 7))
        0, 1, 2: f3 = 3'd0;
        3, 4:    f3 = 3'd1;
        5, 6:    f3 = 3'd2;
        default: f3 = 3'($urandom_range(3, 7));
      endcase
      step("rand", 1'($urandom_range(0, 1)), f3, $urandom, $urandom,
           1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
